// File: rtl/video_timing_monitor.sv
// rtl/video_timing_monitor.sv - passive hs/vs/de timing measurement and lock monitor
module video_timing_monitor #(
   parameter int          X_BITS          = 12,
   parameter int          Y_BITS          = 12,
   parameter int          LOCK_FRAMES     = 3,
   parameter logic [23:0] WATCHDOG_CYCLES = 24'd4_000_000
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              de_in,
   input  logic [X_BITS-1:0] exp_h_total,
   input  logic [X_BITS-1:0] exp_h_active,
   input  logic [Y_BITS-1:0] exp_v_total,
   input  logic [Y_BITS-1:0] exp_v_active,
   output logic [X_BITS-1:0] h_total,
   output logic [X_BITS-1:0] h_active,
   output logic [Y_BITS-1:0] v_total,
   output logic [Y_BITS-1:0] v_active,
   output logic              meas_valid,
   output logic              frame_match,
   output logic              locked,
   output logic              no_signal,
   output logic [15:0]       unlock_count
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   localparam logic [X_BITS-1:0] X_ONE       = X_BITS'(1);
   localparam logic [Y_BITS-1:0] Y_ONE       = Y_BITS'(1);
   localparam logic [3:0]        LOCK_TARGET = 4'(LOCK_FRAMES);

   logic              hs_rise;
   logic              vs_rise;
   logic              meas_evt;
   logic              wd_evt;
   logic              frame_ok;

   logic              hs_dly_q,        hs_dly_d;
   logic              vs_dly_q,        vs_dly_d;
   logic [X_BITS-1:0] h_cnt_q,         h_cnt_d;
   logic [X_BITS-1:0] line_period_q,   line_period_d;
   logic [X_BITS-1:0] de_cnt_q,        de_cnt_d;
   logic [X_BITS-1:0] line_active_q,   line_active_d;
   logic [Y_BITS-1:0] line_cnt_q,      line_cnt_d;
   logic [Y_BITS-1:0] line_de_cnt_q,   line_de_cnt_d;
   logic              line_mismatch_q, line_mismatch_d;
   logic              first_line_q,    first_line_d;
   logic              seen_vs_q,       seen_vs_d;
   logic [23:0]       wd_cnt_q,        wd_cnt_d;
   logic [X_BITS-1:0] h_total_q,       h_total_d;
   logic [X_BITS-1:0] h_active_q,      h_active_d;
   logic [Y_BITS-1:0] v_total_q,       v_total_d;
   logic [Y_BITS-1:0] v_active_q,      v_active_d;
   logic              meas_valid_q,    meas_valid_d;
   logic              frame_match_q,   frame_match_d;
   logic              locked_q,        locked_d;
   logic              no_signal_q,     no_signal_d;
   logic [15:0]       unlock_count_q,  unlock_count_d;
   logic [3:0]        good_cnt_q,      good_cnt_d;
   state_t            state_q,         state_d;

   // Line and frame measurement, capture at frame close, and the vs watchdog
   always_comb begin
      hs_rise         = hs_in & ~hs_dly_q;
      vs_rise         = vs_in & ~vs_dly_q;
      hs_dly_d        = hs_in;
      vs_dly_d        = vs_in;
      h_cnt_d         = h_cnt_q;
      line_period_d   = line_period_q;
      de_cnt_d        = de_cnt_q;
      line_active_d   = line_active_q;
      line_cnt_d      = line_cnt_q;
      line_de_cnt_d   = line_de_cnt_q;
      line_mismatch_d = line_mismatch_q;
      first_line_d    = first_line_q;
      seen_vs_d       = seen_vs_q;
      wd_cnt_d        = wd_cnt_q;
      h_total_d       = h_total_q;
      h_active_d      = h_active_q;
      v_total_d       = v_total_q;
      v_active_d      = v_active_q;
      meas_valid_d    = 1'b0;
      frame_match_d   = frame_match_q;
      no_signal_d     = no_signal_q;
      meas_evt        = 1'b0;
      wd_evt          = 1'b0;
      frame_ok        = 1'b0;

      if (hs_rise) begin
         line_period_d = h_cnt_q;
         h_cnt_d       = X_ONE;
         if (de_cnt_q != '0) begin
            line_active_d = de_cnt_q;
            line_de_cnt_d = (line_de_cnt_q == '1) ? line_de_cnt_q : line_de_cnt_q + Y_ONE;
         end
         de_cnt_d   = de_in ? X_ONE : '0;
         line_cnt_d = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + Y_ONE;
         // The first period after vs straddles the frame boundary, so it is not compared
         if (!first_line_q && (h_cnt_q != line_period_q)) begin
            line_mismatch_d = 1'b1;
         end
         first_line_d = 1'b0;
      end else begin
         h_cnt_d = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + X_ONE;
         if (de_in) begin
            de_cnt_d = (de_cnt_q == '1) ? de_cnt_q : de_cnt_q + X_ONE;
         end
      end

      // Uses the post-hs values so a coincident hs edge is credited to the closing frame
      frame_ok = (line_period_d == exp_h_total) && (line_active_d == exp_h_active) &&
                 (line_cnt_d == exp_v_total) && (line_de_cnt_d == exp_v_active) &&
                 !line_mismatch_d;

      if (vs_rise) begin
         if (seen_vs_q) begin
            meas_evt      = 1'b1;
            meas_valid_d  = 1'b1;
            h_total_d     = line_period_d;
            h_active_d    = line_active_d;
            v_total_d     = line_cnt_d;
            v_active_d    = line_de_cnt_d;
            frame_match_d = frame_ok;
         end
         seen_vs_d       = 1'b1;
         line_cnt_d      = '0;
         line_de_cnt_d   = '0;
         line_mismatch_d = 1'b0;
         first_line_d    = 1'b1;
         wd_cnt_d        = '0;
         no_signal_d     = 1'b0;
      end else if (wd_cnt_q != WATCHDOG_CYCLES) begin
         wd_cnt_d = wd_cnt_q + 24'd1;
         if (wd_cnt_q == WATCHDOG_CYCLES - 24'd1) begin
            wd_evt      = 1'b1;
            no_signal_d = 1'b1;
            seen_vs_d   = 1'b0;
         end
      end
   end

   // Lock state machine, stepped by each measurement or watchdog expiry
   always_comb begin
      state_d        = state_q;
      good_cnt_d     = good_cnt_q;
      unlock_count_d = unlock_count_q;
      if (meas_evt || wd_evt) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (meas_evt && frame_ok) begin
                  good_cnt_d = 4'd1;
                  state_d    = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (meas_evt && frame_ok) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if ((good_cnt_q + 4'd1) == LOCK_TARGET) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  good_cnt_d = 4'd0;
                  state_d    = ST_UNLOCKED;
               end
            end
            ST_LOCKED: begin
               if (!(meas_evt && frame_ok)) begin
                  good_cnt_d = 4'd0;
                  state_d    = ST_UNLOCKED;
                  if (unlock_count_q != 16'hFFFF) begin
                     unlock_count_d = unlock_count_q + 16'd1;
                  end
               end
            end
            default: begin
               good_cnt_d = 4'd0;
               state_d    = ST_UNLOCKED;
            end
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (reset) begin
         hs_dly_q        <= 1'b0;
         vs_dly_q        <= 1'b0;
         h_cnt_q         <= '0;
         line_period_q   <= '0;
         de_cnt_q        <= '0;
         line_active_q   <= '0;
         line_cnt_q      <= '0;
         line_de_cnt_q   <= '0;
         line_mismatch_q <= 1'b0;
         first_line_q    <= 1'b0;
         seen_vs_q       <= 1'b0;
         wd_cnt_q        <= '0;
         h_total_q       <= '0;
         h_active_q      <= '0;
         v_total_q       <= '0;
         v_active_q      <= '0;
         meas_valid_q    <= 1'b0;
         frame_match_q   <= 1'b0;
         locked_q        <= 1'b0;
         no_signal_q     <= 1'b0;
         unlock_count_q  <= '0;
         good_cnt_q      <= '0;
         state_q         <= ST_UNLOCKED;
      end else begin
         hs_dly_q        <= hs_dly_d;
         vs_dly_q        <= vs_dly_d;
         h_cnt_q         <= h_cnt_d;
         line_period_q   <= line_period_d;
         de_cnt_q        <= de_cnt_d;
         line_active_q   <= line_active_d;
         line_cnt_q      <= line_cnt_d;
         line_de_cnt_q   <= line_de_cnt_d;
         line_mismatch_q <= line_mismatch_d;
         first_line_q    <= first_line_d;
         seen_vs_q       <= seen_vs_d;
         wd_cnt_q        <= wd_cnt_d;
         h_total_q       <= h_total_d;
         h_active_q      <= h_active_d;
         v_total_q       <= v_total_d;
         v_active_q      <= v_active_d;
         meas_valid_q    <= meas_valid_d;
         frame_match_q   <= frame_match_d;
         locked_q        <= locked_d;
         no_signal_q     <= no_signal_d;
         unlock_count_q  <= unlock_count_d;
         good_cnt_q      <= good_cnt_d;
         state_q         <= state_d;
      end
   end

   assign h_total      = h_total_q;
   assign h_active     = h_active_q;
   assign v_total      = v_total_q;
   assign v_active     = v_active_q;
   assign meas_valid   = meas_valid_q;
   assign frame_match  = frame_match_q;
   assign locked       = locked_q;
   assign no_signal    = no_signal_q;
   assign unlock_count = unlock_count_q;

endmodule

// File: doc/video_timing_monitor.md
Name: video_timing_monitor

Overview:
- Passive checker on the HDMI test-pattern video bus: samples the registered hs/vs/de driven to the ADV7511 and measures horizontal total, horizontal active, vertical total and vertical active per vs period.
- Compares each measurement against the expected mode values, runs a lock state machine and counts loss-of-lock events.
- Results go to status LEDs/debug; the block never alters the video path.

Parameters:
- X_BITS, 12, width of horizontal measurements.
- Y_BITS, 12, width of vertical measurements.
- LOCK_FRAMES, 3, consecutive matching frames needed to lock (1..15).
- WATCHDOG_CYCLES, 24'd4_000_000, clocks without a vs rising edge before no_signal.

Ports:
- clk_in  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high.
- hs_in  in  1  hsync, active-high.
- vs_in  in  1  vsync, active-high.
- de_in  in  1  data enable, active-high.
- exp_h_total  in  X_BITS  expected clocks per line.
- exp_h_active  in  X_BITS  expected de clocks per line.
- exp_v_total  in  Y_BITS  expected lines per vs period.
- exp_v_active  in  Y_BITS  expected lines containing de.
- h_total  out  X_BITS  measured line period.
- h_active  out  X_BITS  measured de width.
- v_total  out  Y_BITS  measured lines per period.
- v_active  out  Y_BITS  measured active lines.
- meas_valid  out  1  one-cycle pulse when measurements update.
- frame_match  out  1  last measured frame matched expected values.
- locked  out  1  lock state machine in LOCKED.
- no_signal  out  1  watchdog expired.
- unlock_count  out  16  saturating count of LOCKED->UNLOCKED transitions.

Behaviour:
- Reset: all outputs 0, all counters 0, FSM UNLOCKED, seen_vs=0.
- Edge detect: hs_d/vs_d registered. hs_rise = hs_in & ~hs_d; vs_rise = vs_in & ~vs_d.
- h_cnt: on hs_rise, line_period <= h_cnt and h_cnt <= 1. Otherwise increments, saturating at all-ones. A 2200-clock line therefore captures 2200.
- de_cnt:
  - Counts de_in-high clocks, saturating.
  - On hs_rise: if de_cnt != 0, line_active <= de_cnt and line_de_cnt increments. Then de_cnt <= de_in (0 or 1).
- line_cnt: increments on every hs_rise, saturating.
- line_mismatch (sticky per frame): set when a new line_period differs from the previous line_period. The first line after vs is exempt.
- Simultaneous hs_rise and vs_rise: the hs event is credited to the ending frame first (period, line_cnt, line_de_cnt), then the frame closes. Per-frame counters restart at 0.
- vs_rise with seen_vs=0: set seen_vs, clear frame counters, no capture (partial frame discarded).
- vs_rise with seen_vs=1, in the next cycle:
  - Register h_total=line_period, h_active=line_active, v_total=line_cnt, v_active=line_de_cnt.
  - Pulse meas_valid for one cycle.
  - frame_match = (all four equal expected) & ~line_mismatch.
  - Latency: one clock from the cycle vs_in is first sampled high.
- Watchdog:
  - 24-bit counter clears on vs_rise.
  - On reaching WATCHDOG_CYCLES it sets no_signal=1 and seen_vs=0, and forces an FSM mismatch event.
  - The counter then holds. no_signal clears on the next vs_rise.
- FSM (evaluated on each meas_valid or watchdog event):
  - UNLOCKED: match -> ACQUIRE with good_cnt=1, or straight to LOCKED if LOCKE_FRAMES=1. Mismatch stays UNLOCKED.
  - ACQUIRE: match -> good_cnt+1; on reaching LOCK_FRAMES -> LOCKED. Mismatch -> UNLOCKED, good_cnt=0.
  - LOCKED: match stays LOCKED. Mismatch -> UNLOCKED and unlock_count+1, saturating at 16'hFFFF.
- locked is registered from the state and asserts in the same cycle as the meas_valid that completes lock.
- Expected inputs are sampled only at compare time and may change freely.
- Reset mid-frame: everything returns to reset values. The first subsequent vs_rise only arms capture.

Test Plan:
- Small mode (h_total 20, h_active 12, v_total 10, v_active 6, hs/vs coincident), expected values equal -> meas_valid on the 2nd vs_rise with 20/12/10/6. locked=1 at the 4th vs_rise (LOCK_FRAMES=3). unlock_count=0.
- Same stimulus, exp_h_active=13 -> frame_match=0 every frame, locked stays 0, unlock_count=0.
- Locked stream; one line stretched to 21 clocks -> that frame: line_mismatch, frame_match=0, locked drops to 0 one clock after vs, unlock_count=1. Relock after 3 clean frames.
- Locked stream, then vs held low with WATCHDOG_CYCLES=500 -> no_signal=1 exactly 500 clocks after the last vs_rise, locked=0, unlock_count+1. The first restored vs_rise clears no_signal with no meas_valid; the next vs_rise gives a valid measurement.
- vs_rise offset 10 clocks from hs_rise -> v_total still 10 and v_active 6. Measurement is identical to the coincident case.
- Assert reset for 1 cycle mid-frame while locked -> all outputs 0 next cycle. No meas_valid until the 2nd post-reset vs_rise.
